// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared encodings for the data-memory access controller:
//            access-size codes, FSM state codes and an alignment helper.
// Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;
    localparam logic [1:0] c_size_rsvd = 2'b11;

    // Controller FSM state encodings
    localparam int         c_state_w   = 3;
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_rd     = 3'd1;
    localparam logic [2:0] c_st_rmw_rd = 3'd2;
    localparam logic [2:0] c_st_wr     = 3'd3;
    localparam logic [2:0] c_st_resp   = 3'd4;

    // A half access must sit on an even byte, a word access on a word boundary
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic r;
        case (size)
            c_size_half: r = offset[0];
            c_size_word: r = (offset != 2'b00);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : byte_lane_align
// Purpose  : Combinational lane steering. Extracts and extends a load from a
//            memory word, and merges right-aligned store data into the lanes
//            of a previously read word (little-endian lanes).
// Revision : 1.0  initial release
// ============================================================================
module byte_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_is_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [31:0] w_shifted;

    // Bring the addressed byte/half down to bit 0
    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    // Load extension: zero or sign extend the selected lane(s)
    always_comb begin
        o_load_data = w_shifted;
        case (i_size)
            c_size_byte: o_load_data = i_is_unsigned ? {24'h0, w_shifted[7:0]}
                                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_size_half: o_load_data = i_is_unsigned ? {16'h0, w_shifted[15:0]}
                                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:     o_load_data = w_shifted;
        endcase
    end

    // Store merge: each lane takes new data when selected, else keeps the read word
    for (genvar k = 0; k < 4; k++) begin : g_lane
        localparam logic [1:0] c_k = 2'(k);
        logic       w_sel;
        logic [7:0] w_src;

        // Lane select and source byte for this lane
        always_comb begin
            w_sel = 1'b1;
            w_src = i_wdata[8*k +: 8];
            case (i_size)
                c_size_byte: begin
                    w_sel = (i_offset == c_k);
                    w_src = i_wdata[7:0];
                end
                c_size_half: begin
                    w_sel = (i_offset[1] == c_k[1]);
                    w_src = c_k[0] ? i_wdata[15:8] : i_wdata[7:0];
                end
                default: begin
                    w_sel = 1'b1;
                    w_src = i_wdata[8*k +: 8];
                end
            endcase
        end

        assign o_store_word[8*k +: 8] = w_sel ? w_src : i_rdata[8*k +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Initiator side of the data-memory port. Accepts byte/half/word
//            loads and stores, does read-modify-write for sub-word stores and
//            aligns/extends load data. One request in flight at a time.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemToWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    localparam logic [31:0] c_depth = 32'(DEPTH);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_next;

    // Latched request fields
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;

    // Output registers
    logic        r_mem_we;
    logic [31:0] r_addr;
    logic [31:0] r_mem_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    // Next values for the output registers
    logic        w_mem_we_nxt;
    logic [31:0] w_mem_wdata_nxt;
    logic        w_resp_valid_nxt;
    logic [31:0] w_resp_rdata_nxt;
    logic        w_resp_err_nxt;

    logic        w_accept;
    logic        w_req_err;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

    assign req_ready = (r_state == c_st_idle);
    assign w_accept  = req_valid && req_ready;

    // Out-of-range word index, misaligned address or reserved size
    assign w_req_err = (req_size == c_size_rsvd)
                    || is_misaligned(req_size, req_addr[1:0])
                    || ({2'b00, req_addr[31:2]} >= c_depth);

    byte_lane_align u_align (
        .i_rdata       (ReadData),
        .i_offset      (r_off),
        .i_size        (r_size),
        .i_is_unsigned (r_unsigned),
        .i_wdata       (r_wdata),
        .o_load_data   (w_load_data),
        .o_store_word  (w_store_word)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (req_valid) begin
                    if (w_req_err)                     w_state_next = c_st_resp;
                    else if (!req_we)                  w_state_next = c_st_rd;
                    else if (req_size == c_size_word)  w_state_next = c_st_wr;
                    else                               w_state_next = c_st_rmw_rd;
                end
            end
            c_st_rd:     w_state_next = c_st_resp;
            c_st_rmw_rd: w_state_next = c_st_wr;
            c_st_wr:     w_state_next = c_st_resp;
            c_st_resp:   w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    // FSM outputs: next values of the registered memory and response ports
    always_comb begin
        w_mem_we_nxt     = (w_state_next == c_st_wr);
        w_mem_wdata_nxt  = r_mem_wdata;
        w_resp_valid_nxt = (w_state_next == c_st_resp);
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;

        // Full-word stores go straight to memory; sub-word stores take the merged word
        if ((r_state == c_st_idle) && (w_state_next == c_st_wr)) begin
            w_mem_wdata_nxt = req_wdata;
        end else if (r_state == c_st_rmw_rd) begin
            w_mem_wdata_nxt = w_store_word;
        end

        // Response payload is only updated when a response is issued, then held
        if (w_state_next == c_st_resp) begin
            w_resp_rdata_nxt = (r_state == c_st_rd) ? w_load_data : 32'h0;
            w_resp_err_nxt   = (r_state == c_st_idle);
        end
    end

    // Request field latches, captured on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size     <= c_size_byte;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_wdata    <= 32'h0;
            r_addr     <= 32'h0;
        end else if (w_accept) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_off      <= req_addr[1:0];
            r_wdata    <= req_wdata;
            r_addr     <= {2'b00, req_addr[31:2]};
        end
    end

    // Output registers; async reset drops the write enable immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            r_mem_we     <= w_mem_we_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    assign MemToWrite = r_mem_we;
    assign Address    = r_addr;
    assign WriteData  = r_mem_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Scoreboard bench for mem_access_ctrl with a behavioural
//            word-indexed data memory attached to the memory port.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemToWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec;
    int          n_bad;
    int          cyc;
    int          wr_count;

    logic [31:0] mem [0:127];
    logic        pl_en;
    logic [6:0]  pl_idx;
    logic [31:0] pl_data;

    mem_access_ctrl #(.DEPTH(128)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .MemToWrite   (MemToWrite),
        .Address      (Address),
        .WriteData    (WriteData),
        .ReadData     (ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, posedge write, bench preload port
    assign ReadData = (Address < 32'd128) ? mem[Address[6:0]] : 32'h0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (MemToWrite && (Address < 32'd128)) mem[Address[6:0]] <= WriteData;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (MemToWrite) wr_count <= wr_count + 1;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: pop the oldest expectation whenever a response appears
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_resp: got resp_valid=1, expected no response (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rd);
                chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr, input int elat,
                         input bit hold, input bit expect_resp);
        int   t;
        exp_t e;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        t = 0;
        while (!req_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got req_ready=0 for 40 cycles, expected 1");
            req_valid = 1'b0;
            return;
        end
        if (expect_resp) begin
            e.rd  = erd;
            e.err = eerr;
            e.lat = elat;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic preload(input logic [6:0] idx, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = data;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL resp_timeout: got %0d pending responses, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int wc;
        n_vec = 0; n_bad = 0; cyc = 0; wr_count = 0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset state
        #1;
        chk("rst_MemToWrite", {31'h0, MemToWrite}, 32'h0);
        chk("rst_Address", Address, 32'h0);
        chk("rst_WriteData", WriteData, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

        preload(7'd2, 32'h11223344);
        preload(7'd3, 32'hDEADBEEF);
        preload(7'd4, 32'h00000000);
        preload(7'd5, 32'h55555555);
        preload(7'd7, 32'h80017F80);

        // Loads of each size and extension
        issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 1'b1);
        drain();
        issue(1'b0, 2'b00, 1'b0, 32'h0F, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1'b0, 1'b1);
        drain();
        issue(1'b0, 2'b00, 1'b1, 32'h0F, 32'h0, 32'h000000DE, 1'b0, 2, 1'b0, 1'b1);
        drain();
        issue(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 1'b0, 1'b1);
        drain();
        issue(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, 32'h0000BEEF, 1'b0, 2, 1'b0, 1'b1);
        drain();

        // Byte store via read-modify-write
        wc = wr_count;
        issue(1'b1, 2'b00, 1'b0, 32'h09, 32'h000000AB, 32'h0, 1'b0, 3, 1'b0, 1'b1);
        drain();
        chk("store_byte_mem2", mem[2], 32'h1122AB44);
        chk("store_byte_pulses", 32'(wr_count - wc), 32'd1);

        // Half store into upper lanes, then read lanes back
        issue(1'b1, 2'b01, 1'b0, 32'h1E, 32'h1234BEEF, 32'h0, 1'b0, 3, 1'b0, 1'b1);
        drain();
        chk("store_half_mem7", mem[7], 32'hBEEF7F80);
        issue(1'b0, 2'b00, 1'b0, 32'h1C, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b0, 1'b1);
        drain();
        issue(1'b0, 2'b00, 1'b1, 32'h1F, 32'h0, 32'h000000BE, 1'b0, 2, 1'b0, 1'b1);
        drain();

        // Error cases: no memory write, response one cycle after accept
        wc = wr_count;
        issue(1'b0, 2'b01, 1'b0, 32'h03,  32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        drain();
        issue(1'b0, 2'b11, 1'b0, 32'h00,  32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        drain();
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        drain();
        issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        drain();
        issue(1'b1, 2'b01, 1'b0, 32'h05, 32'h12345678, 32'h0, 1'b1, 1, 1'b0, 1'b1);
        drain();
        chk("err_no_write", 32'(wr_count - wc), 32'd0);

        // Back-to-back: word store then load of the same word with req_valid held
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h0BADCAFE, 32'h0, 1'b0, 2, 1'b1, 1'b1);
        chk("b2b_ready_low", {31'h0, req_ready}, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0BADCAFE, 1'b0, 2, 1'b0, 1'b1);
        drain();

        // Reset in the middle of a word store to mem[5]
        issue(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        chk("wr_before_reset", {31'h0, MemToWrite}, 32'h1);
        #1 rst_n = 1'b0;
        #1 chk("wr_async_drop", {31'h0, MemToWrite}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_mem5", mem[5], 32'h55555555);
        chk("reset_ready", {31'h0, req_ready}, 32'h1);

        // Controller is usable again after the abort
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h55555555, 1'b0, 2, 1'b0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
